// File: rtl/prog_loader_if.sv
// Byte-stream valid/ready link feeding the program loader.
// master: stream source (drives byte_in/byte_valid); slave: loader (drives byte_ready).
interface prog_loader_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;

  modport master (
    output byte_in,
    output byte_valid,
    input  byte_ready
  );

  modport slave (
    input  byte_in,
    input  byte_valid,
    output byte_ready
  );
endinterface

// File: rtl/prog_loader.sv
// Boot-time loader: LE byte stream (16-bit count + 32-bit words) -> imem writes.
// Ports: clock/reset(sync, low), start, bs (byte stream), imem_*, cpu_load, done, overflow, words_loaded.
module prog_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  prog_loader_if.slave      bs,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_load,
  output logic              done,
  output logic              overflow,
  output logic [15:0]       words_loaded
);

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] wl_q, wl_d;
  logic        ovf_q, ovf_d;

  logic rdy;
  logic accept;
  logic in_range;
  logic [15:0] wl_inc;

  assign rdy      = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                    (state_q == DATA);
  assign accept   = rdy && bs.byte_valid;
  // Word index still fits in memory when no bits above ADDR_W are set.
  assign in_range = (wl_q >> ADDR_W) == 16'd0;
  assign wl_inc   = wl_q + 16'd1;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    word_d  = word_q;
    idx_d   = idx_q;
    wl_d    = wl_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LEN_LO;
          ovf_d   = 1'b0;
          wl_d    = 16'd0;
        end
      end
      LEN_LO: begin
        if (accept) begin
          len_d[7:0] = bs.byte_in;
          state_d    = LEN_HI;
        end
      end
      LEN_HI: begin
        if (accept) begin
          len_d[15:8] = bs.byte_in;
          idx_d       = 2'd0;
          state_d     = ({bs.byte_in, len_q[7:0]} == 16'd0) ? DONE : DATA;
        end
      end
      DATA: begin
        if (accept) begin
          word_d[{idx_q, 3'b000} +: 8] = bs.byte_in;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = WRITE;
        end
      end
      WRITE: begin
        wl_d = wl_inc;
        // Out-of-range words are still counted so the stream stays framed.
        if (!in_range) ovf_d = 1'b1;
        state_d = (wl_inc == len_q) ? DONE : DATA;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      word_q  <= '0;
      idx_q   <= '0;
      wl_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      wl_q    <= wl_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bs.byte_ready = rdy;
  assign imem_we       = (state_q == WRITE) && in_range;
  assign imem_addr     = wl_q[ADDR_W-1:0];
  assign imem_wdata    = word_q;
  assign cpu_load      = rdy || (state_q == WRITE);
  assign done          = (state_q == DONE);
  assign overflow      = ovf_q;
  assign words_loaded  = wl_q;

endmodule
